uart_baud_irq_mch: RTL and testbench

Multi-channel successor to the single-UART register block. It provides NCH independent register sets behind one Wishbone-style slave port. Each set holds a divisor latch with a fractional part, an interrupt enable, a control register and a scratch register. Per channel it generates baud enable strobes using fractional accumulation, and prioritised interrupt identification from status levels supplied by external transmitter and receiver blocks.

---
 rtl/uart_baud_irq_mch.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_uart_baud_irq_mch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_irq_mch.sv
// -----------------------------------------------------------------------------
// uart_baud_irq_mch
// Multi-channel UART support register block. One Wishbone-style slave port
// gives access to NCH independent register sets. Each set has a divisor latch
// with a fractional part, an interrupt enable, a control register and a
// scratch register. Each channel produces a fractional-N baud enable strobe
// and a prioritised interrupt identification built from the status levels
// supplied by the external transmitter and receiver blocks.
//
// Ports
//   clk          system clock
//   wb_rst_i     asynchronous reset, active low
//   wb_addr_i    {channel, register offset}
//   wb_dat_i     write data
//   wb_dat_o     read data, combinational from wb_addr_i
//   wb_we_i      write strobe, one cycle per access
//   wb_re_i      read strobe, one cycle per access
//   rx_rda_i     per-channel receive-data-available level
//   rx_err_i     per-channel line-status-error level
//   tx_empty_i   per-channel transmit-FIFO-empty level
//   baud_o       per-channel one-cycle baud enable strobe (registered)
//   int_o        per-channel interrupt (registered)
//   int_any_o    OR of all channel interrupts (registered)
//
// Register offsets: 0 DLL, 1 DLM, 2 DLF, 3 IER, 4 IIR (RO), 5 CTRL, 6 SCR,
// 7 STAT (RO).
// -----------------------------------------------------------------------------
module uart_baud_irq_mch #(
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic                clk,
  input  logic                wb_rst_i,
  input  logic [CH_W+2:0]     wb_addr_i,
  input  logic [7:0]          wb_dat_i,
  output logic [7:0]          wb_dat_o,
  input  logic                wb_we_i,
  input  logic                wb_re_i,
  input  logic [NCH-1:0]      rx_rda_i,
  input  logic [NCH-1:0]      rx_err_i,
  input  logic [NCH-1:0]      tx_empty_i,
  output logic [NCH-1:0]      baud_o,
  output logic [NCH-1:0]      int_o,
  output logic                int_any_o
);

  localparam logic [DIV_W-1:0] DL_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DL_ZERO = DIV_W'(0);

  localparam logic [2:0] OFF_DLL  = 3'd0;
  localparam logic [2:0] OFF_DLM  = 3'd1;
  localparam logic [2:0] OFF_DLF  = 3'd2;
  localparam logic [2:0] OFF_IER  = 3'd3;
  localparam logic [2:0] OFF_IIR  = 3'd4;
  localparam logic [2:0] OFF_CTRL = 3'd5;
  localparam logic [2:0] OFF_SCR  = 3'd6;
  localparam logic [2:0] OFF_STAT = 3'd7;

  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_THRE = 4'b0010;

  logic [CH_W-1:0]              ch_sel_s;
  logic [2:0]                   off_s;
  logic                         ch_ok_s;
  logic                         wr_s;
  logic                         rd_s;
  logic [2**CH_W-1:0][7:0]      rdata_all_s;
  logic [NCH-1:0]               int_nxt_s;
  logic                         int_any_r;

  assign ch_sel_s = wb_addr_i[CH_W+2:3];
  assign off_s    = wb_addr_i[2:0];
  assign ch_ok_s  = ({1'b0, ch_sel_s} < (CH_W+1)'(NCH));
  // A simultaneous read and write is illegal: neither side effect happens.
  assign wr_s     = wb_we_i & ~wb_re_i;
  assign rd_s     = wb_re_i & ~wb_we_i;

  // Unpopulated channel slots read as zero.
  assign wb_dat_o = rdata_all_s[ch_sel_s];

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(c);

      logic              sel_s;
      logic              wr_ch_s;
      logic              rd_ch_s;

      logic [7:0]        dll_r, dll_s;
      logic [7:0]        dlm_r, dlm_s;
      logic [FRAC_W-1:0] dlf_r, dlf_s;
      logic [2:0]        ier_r, ier_s;
      logic              en_r, en_s;
      logic [7:0]        scr_r, scr_s;
      logic              dl_wr_s;

      logic [DIV_W-1:0]  dl_r_s;
      logic [DIV_W-1:0]  dl_nxt_s;
      logic [DIV_W-1:0]  cnt_r, cnt_s;
      logic [FRAC_W-1:0] acc_r, acc_s;
      logic [FRAC_W:0]   sum_s;
      logic              reload_s;
      logic              strobe_s;
      logic              baud_r;

      logic              tx_empty_d_r;
      logic              thre_p_r, thre_p_s;
      logic              tx_rise_s;
      logic              ier_thre_set_s;
      logic              iir_rd_clr_s;
      logic [3:0]        iir_r, iir_s;
      logic              int_r;
      logic [7:0]        rdata_s;

      assign sel_s   = ch_ok_s & (ch_sel_s == CH_IDX);
      assign wr_ch_s = wr_s & sel_s;
      assign rd_ch_s = rd_s & sel_s;
      assign dl_r_s  = {dlm_r, dll_r};

      // Register-file next values from the bus write.
      always_comb begin
        dll_s   = dll_r;
        dlm_s   = dlm_r;
        dlf_s   = dlf_r;
        ier_s   = ier_r;
        en_s    = en_r;
        scr_s   = scr_r;
        dl_wr_s = 1'b0;
        if (wr_ch_s) begin
          case (off_s)
            OFF_DLL:  begin dll_s = wb_dat_i;               dl_wr_s = 1'b1; end
            OFF_DLM:  begin dlm_s = wb_dat_i;               dl_wr_s = 1'b1; end
            OFF_DLF:  begin dlf_s = wb_dat_i[FRAC_W-1:0];   dl_wr_s = 1'b1; end
            OFF_IER:  ier_s = wb_dat_i[2:0];
            OFF_CTRL: en_s  = wb_dat_i[0];
            OFF_SCR:  scr_s = wb_dat_i;
            default:  dl_wr_s = 1'b0;
          endcase
        end else begin
          dl_wr_s = 1'b0;
        end
      end

      assign dl_nxt_s = {dlm_s, dll_s};
      // Divisor change, enable rising, or enable low all restart the period.
      assign reload_s = dl_wr_s | (en_s & ~en_r) | ~en_s;
      assign sum_s    = {1'b0, acc_r} + {1'b0, dlf_r};

      // Baud down-counter with fractional accumulator: the accumulator
      // carry stretches the following period by one cycle.
      always_comb begin
        cnt_s    = cnt_r;
        acc_s    = acc_r;
        strobe_s = 1'b0;
        if (reload_s) begin
          cnt_s    = dl_nxt_s - DL_ONE;
          acc_s    = {FRAC_W{1'b0}};
          strobe_s = 1'b0;
        end else if (dl_r_s == DL_ZERO) begin
          cnt_s    = cnt_r;
          acc_s    = acc_r;
          strobe_s = 1'b0;
        end else if (cnt_r == DL_ZERO) begin
          strobe_s = 1'b1;
          acc_s    = sum_s[FRAC_W-1:0];
          cnt_s    = dl_r_s - DL_ONE + DIV_W'(sum_s[FRAC_W]);
        end else begin
          cnt_s    = cnt_r - DL_ONE;
          strobe_s = 1'b0;
        end
      end

      assign tx_rise_s      = tx_empty_i[c] & ~tx_empty_d_r;
      assign ier_thre_set_s = wr_ch_s & (off_s == OFF_IER) & wb_dat_i[1] &
                              ~ier_r[1] & tx_empty_i[c];
      assign iir_rd_clr_s   = rd_ch_s & (off_s == OFF_IIR) & (iir_r == IIR_THRE);

      // THRE pending flag; a new set beats a same-cycle read clear.
      always_comb begin
        if (~tx_empty_i[c] | ~ier_s[1]) begin
          thre_p_s = 1'b0;
        end else if (tx_rise_s | ier_thre_set_s) begin
          thre_p_s = 1'b1;
        end else if (iir_rd_clr_s) begin
          thre_p_s = 1'b0;
        end else begin
          thre_p_s = thre_p_r;
        end
      end

      // Interrupt identification in priority order RLS > RDA > THRE.
      always_comb begin
        if (ier_s[2] & rx_err_i[c]) begin
          iir_s = IIR_RLS;
        end else if (ier_s[0] & rx_rda_i[c]) begin
          iir_s = IIR_RDA;
        end else if (thre_p_s) begin
          iir_s = IIR_THRE;
        end else begin
          iir_s = IIR_NONE;
        end
      end

      assign int_nxt_s[c] = ~iir_s[0];

      // Read-data mux for this channel.
      always_comb begin
        case (off_s)
          OFF_DLL:  rdata_s = dll_r;
          OFF_DLM:  rdata_s = dlm_r;
          OFF_DLF:  rdata_s = 8'(dlf_r);
          OFF_IER:  rdata_s = {5'b00000, ier_r};
          OFF_IIR:  rdata_s = {4'b1100, iir_r};
          OFF_CTRL: rdata_s = {7'b0000000, en_r};
          OFF_SCR:  rdata_s = scr_r;
          OFF_STAT: rdata_s = {5'b00000, tx_empty_i[c], rx_err_i[c], rx_rda_i[c]};
          default:  rdata_s = 8'h00;
        endcase
      end

      assign rdata_all_s[c] = rdata_s;

      // Channel state registers.
      always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
          dll_r        <= 8'h00;
          dlm_r        <= 8'h00;
          dlf_r        <= {FRAC_W{1'b0}};
          ier_r        <= 3'b000;
          en_r         <= 1'b0;
          scr_r        <= 8'h00;
          cnt_r        <= DL_ZERO;
          acc_r        <= {FRAC_W{1'b0}};
          baud_r       <= 1'b0;
          tx_empty_d_r <= 1'b0;
          thre_p_r     <= 1'b0;
          iir_r        <= IIR_NONE;
          int_r        <= 1'b0;
        end else begin
          dll_r        <= dll_s;
          dlm_r        <= dlm_s;
          dlf_r        <= dlf_s;
          ier_r        <= ier_s;
          en_r         <= en_s;
          scr_r        <= scr_s;
          cnt_r        <= cnt_s;
          acc_r        <= acc_s;
          baud_r       <= strobe_s;
          tx_empty_d_r <= tx_empty_i[c];
          thre_p_r     <= thre_p_s;
          iir_r        <= iir_s;
          int_r        <= int_nxt_s[c];
        end
      end

      assign baud_o[c] = baud_r;
      assign int_o[c]  = int_r;
    end

    for (c = NCH; c < 2**CH_W; c++) begin : g_pad
      assign rdata_all_s[c] = 8'h00;
    end
  endgenerate

  // Aggregate interrupt, registered alongside the per-channel ones.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      int_any_r <= 1'b0;
    end else begin
      int_any_r <= |int_nxt_s;
    end
  end

  assign int_any_o = int_any_r;

endmodule

// File: tb/tb_uart_baud_irq_mch.sv
module tb_uart_baud_irq_mch;
  localparam int NCH  = 4;
  localparam int CH_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [CH_W+2:0]  addr;
  logic [7:0]       dat_i, dat_o;
  logic             we, re;
  logic [NCH-1:0]   rx_rda, rx_err, tx_empty, baud, intr;
  logic             int_any;

  // second build with three channels
  logic [CH_W+2:0]  addr3;
  logic [7:0]       dat3_i, dat3_o;
  logic             we3, re3;
  logic [2:0]       rx3_zero;
  logic [2:0]       baud3, int3;
  logic             int_any3;

  uart_baud_irq_mch #(.NCH(4), .CH_W(2), .DIV_W(16), .FRAC_W(4)) u_dut (
    .clk(clk), .wb_rst_i(rst_n), .wb_addr_i(addr), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_we_i(we), .wb_re_i(re), .rx_rda_i(rx_rda),
    .rx_err_i(rx_err), .tx_empty_i(tx_empty), .baud_o(baud), .int_o(intr),
    .int_any_o(int_any)
  );

  uart_baud_irq_mch #(.NCH(3), .CH_W(2), .DIV_W(16), .FRAC_W(4)) u_dut3 (
    .clk(clk), .wb_rst_i(rst_n), .wb_addr_i(addr3), .wb_dat_i(dat3_i),
    .wb_dat_o(dat3_o), .wb_we_i(we3), .wb_re_i(re3), .rx_rda_i(rx3_zero),
    .rx_err_i(rx3_zero), .tx_empty_i(rx3_zero), .baud_o(baud3), .int_o(int3),
    .int_any_o(int_any3)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } rd_exp_t;

  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      wr_edge;
  rd_exp_t rd_q[$];
  rd_exp_t rd3_q[$];
  int      bq[NCH][$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: read data and baud strobes are compared against the queues.
  always @(negedge clk) begin
    rd_exp_t e;
    int      t;
    if (re) begin
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk(e.name, int'(dat_o), int'(e.val));
      end else begin
        checks++; errors++;
        $display("FAIL rd_unexpected got 0x%0h", dat_o);
      end
    end
    if (re3) begin
      if (rd3_q.size() > 0) begin
        e = rd3_q.pop_front();
        chk(e.name, int'(dat3_o), int'(e.val));
      end else begin
        checks++; errors++;
        $display("FAIL rd3_unexpected got 0x%0h", dat3_o);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (rst_n && baud[c]) begin
        if (bq[c].size() > 0) begin
          t = bq[c].pop_front();
          chk($sformatf("baud%0d_cycle", c), cyc, t);
        end else begin
          checks++; errors++;
          $display("FAIL baud%0d_unexpected at cycle %0d expected none", c, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) tick();
  endtask

  task automatic wr(input int ch, input int off, input logic [7:0] d);
    addr  = {ch[CH_W-1:0], off[2:0]};
    dat_i = d;
    we    = 1'b1;
    tick();
    wr_edge = cyc;
    we    = 1'b0;
  endtask

  task automatic rd(input int ch, input int off, input logic [7:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    addr = {ch[CH_W-1:0], off[2:0]};
    re   = 1'b1;
    rd_q.push_back(e);
    tick();
    re   = 1'b0;
  endtask

  task automatic wr3(input int ch, input int off, input logic [7:0] d);
    addr3  = {ch[CH_W-1:0], off[2:0]};
    dat3_i = d;
    we3    = 1'b1;
    tick();
    we3    = 1'b0;
  endtask

  task automatic rd3(input int ch, input int off, input logic [7:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    addr3 = {ch[CH_W-1:0], off[2:0]};
    re3   = 1'b1;
    rd3_q.push_back(e);
    tick();
    re3   = 1'b0;
  endtask

  initial begin
    int      w, t, x;
    rd_exp_t e;
    rst_n = 1'b0; addr = '0; dat_i = 8'h00; we = 1'b0; re = 1'b0;
    rx_rda = '0; rx_err = '0; tx_empty = '0;
    addr3 = '0; dat3_i = 8'h00; we3 = 1'b0; re3 = 1'b0; rx3_zero = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: reset state
    chk("rst_baud", int'(baud), 0);
    chk("rst_int", int'(intr), 0);
    chk("rst_int_any", int'(int_any), 0);
    rd(0, 4, 8'hC1, "t1_iir");
    rd(0, 7, 8'h00, "t1_stat");
    rx_rda[0] = 1'b1; tx_empty[0] = 1'b1;
    rd(0, 7, 8'h05, "t1_stat_live");
    rx_rda[0] = 1'b0; tx_empty[0] = 1'b0;

    // register masks
    wr(0, 2, 8'hFF); rd(0, 2, 8'h0F, "dlf_mask");
    wr(0, 3, 8'hFF); rd(0, 3, 8'h07, "ier_mask");
    wr(0, 3, 8'h00);

    // 2: ch0 integer divisor 4
    wr(0, 0, 8'd4); wr(0, 1, 8'd0); wr(0, 2, 8'd0);
    wr(0, 5, 8'h01);
    w = wr_edge;
    bq[0].push_back(w + 4); bq[0].push_back(w + 8); bq[0].push_back(w + 12);
    rd(0, 5, 8'h01, "t2_ctrl");
    rd(0, 0, 8'h04, "t2_dll");
    wait_until(w + 13);
    wr(0, 5, 8'h00);

    // 3: ch2 DL=3, DLF=8 -> periods 3,3,4,3,4,...; 16 periods after the first strobe = 56
    wr(2, 0, 8'd3); wr(2, 2, 8'd8);
    wr(2, 5, 8'h01);
    w = wr_edge;
    t = w + 3;
    bq[2].push_back(t);
    for (int k = 2; k <= 17; k++) begin
      t = t + (((k % 2) == 1) ? 4 : 3);
      bq[2].push_back(t);
    end
    wait_until(t);
    wr(2, 2, 8'd8);                 // mid-period rewrite -> full 3-cycle period
    bq[2].push_back(t + 4);
    bq[2].push_back(t + 7);
    wait_until(t + 8);
    wr(2, 5, 8'h00);

    // 4: ch1 priority chain
    wr(1, 3, 8'h07);
    rx_err[1] = 1'b1; rx_rda[1] = 1'b1; tx_empty[1] = 1'b1;
    tick();
    rd(1, 4, 8'hC6, "t4_rls");
    chk("t4_int_hi", int'(intr[1]), 1);
    chk("t4_int_any_hi", int'(int_any), 1);
    rx_err[1] = 1'b0; tick();
    rd(1, 4, 8'hC4, "t4_rda");
    rx_rda[1] = 1'b0; tick();
    chk("t4_int_thre", int'(intr[1]), 1);
    rd(1, 4, 8'hC2, "t4_thre");
    chk("t4_int_fall", int'(intr[1]), 0);
    chk("t4_int_any_fall", int'(int_any), 0);
    rd(1, 4, 8'hC1, "t4_none");
    tx_empty[1] = 1'b0;
    wr(1, 3, 8'h00);

    // 5: ch3 THRE pending
    wr(3, 3, 8'h02);
    tx_empty[3] = 1'b1; tick();
    tx_empty[3] = 1'b0; tick();
    tx_empty[3] = 1'b1;
    rd(3, 4, 8'hC1, "t5_rd_at_rise");
    rd(3, 4, 8'hC2, "t5_pending");
    rd(3, 4, 8'hC1, "t5_cleared");
    wr(3, 3, 8'h00); tick();
    rd(3, 4, 8'hC1, "t5_ier_off");
    wr(3, 3, 8'h02);
    rd(3, 4, 8'hC2, "t5_ier_rise");
    tx_empty[3] = 1'b0;
    wr(3, 3, 8'h00);

    // simultaneous read and write: neither takes effect
    wr(0, 6, 8'h5A);
    addr = {2'd0, 3'd6}; dat_i = 8'hA5; we = 1'b1; re = 1'b1;
    e.name = "rw_illegal_rd"; e.val = 8'h5A; rd_q.push_back(e);
    tick();
    we = 1'b0; re = 1'b0;
    rd(0, 6, 8'h5A, "rw_illegal_scr");

    // 6: three-channel build, slot 3 absent
    for (int i = 0; i < 3; i++) wr3(i, 6, 8'(8'h10 + i));
    wr3(3, 6, 8'hAA);
    rd3(3, 6, 8'h00, "n3_ch3_scr");
    rd3(3, 4, 8'h00, "n3_ch3_iir");
    for (int i = 0; i < 3; i++) rd3(i, 6, 8'(8'h10 + i), $sformatf("n3_ch%0d_scr", i));

    // reset mid-operation
    wr(2, 3, 8'h04); rx_err[2] = 1'b1;
    wr(0, 0, 8'd4);
    wr(0, 5, 8'h01);
    w = wr_edge;
    bq[0].push_back(w + 4);
    wait_until(w + 8);
    chk("pre_rst_strobe", int'(baud[0]), 1);
    chk("pre_rst_int2", int'(intr[2]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_baud", int'(baud), 0);
    chk("rst_async_int", int'(intr), 0);
    chk("rst_async_int_any", int'(int_any), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_int", int'(intr), 0);
    rd(0, 5, 8'h00, "post_rst_ctrl");
    rd(0, 0, 8'h00, "post_rst_dll");
    rd(2, 4, 8'hC1, "post_rst_iir2");
    rx_err[2] = 1'b0;
    repeat (20) tick();

    // DL=0 holds; DL=1 strobes every cycle
    wr(0, 5, 8'h01);
    repeat (10) tick();
    wr(0, 0, 8'd1);
    x = wr_edge;
    for (int k = 1; k <= 5; k++) bq[0].push_back(x + k);
    wait_until(x + 5);
    wr(0, 5, 8'h00);
    repeat (5) tick();

    chk("baud_q_drained", bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size(), 0);
    chk("rd_q_drained", rd_q.size() + rd3_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
